// File: rtl/elevator_bank.sv
// elevator_bank: position controller for NUM_CARS independent cars over NUM_FLOORS floors.
// Each car runs a MOVE / DWELL / FROZEN state machine on the shared step enable. Cars
// reverse automatically at the end floors. A car leaving FROZEN looks at any car parked
// on the same floor and picks the opposite direction.
// All outputs come straight from registers.

module elevator_bank #(
    parameter int NUM_CARS   = 2,
    parameter int NUM_FLOORS = 6,
    parameter int FLOOR_W    = 3,
    parameter int DWELL      = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_step,
    input  logic [NUM_CARS-1:0]           i_emergency,
    input  logic [NUM_CARS-1:0]           i_turn,
    input  logic [NUM_CARS-1:0]           i_hold,
    output logic [NUM_CARS*FLOOR_W-1:0]   o_pos,
    output logic [NUM_CARS-1:0]           o_dir,
    output logic [2*NUM_CARS-1:0]         o_state,
    output logic [NUM_CARS-1:0]           o_door_open
);

    // The dwell counter only has to hold DWELL-1, and it is never narrower than one bit.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = '0;
    localparam logic [FLOOR_W-1:0] ONE_FLOOR    = FLOOR_W'(1);
    localparam logic [CNT_W-1:0]   DWELL_RELOAD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_MOVE   = 2'b00,
        ST_DWELL  = 2'b01,
        ST_FROZEN = 2'b10
    } car_state_t;

    // Per-car registered state; these registers drive the outputs directly.
    logic [FLOOR_W-1:0] r_pos   [NUM_CARS];
    car_state_t         r_state [NUM_CARS];
    logic [CNT_W-1:0]   r_cnt   [NUM_CARS];
    logic [NUM_CARS-1:0] r_dir;
    logic [NUM_CARS-1:0] r_door;

    // Per-car combinational helpers.
    logic [FLOOR_W-1:0] w_mv_pos   [NUM_CARS];
    logic               w_mv_dir   [NUM_CARS];
    logic               w_peer_hit [NUM_CARS];
    logic               w_peer_dir [NUM_CARS];

    // Next floor and direction for a car taking a move step. Turn is applied first,
    // then the end floors force a reversal, so the floor index never wraps.
    always_comb begin
        logic v_eff;
        v_eff = 1'b0;
        // NOTE: every combinational output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        for (int i = 0; i < NUM_CARS; i++) begin
            w_mv_dir[i] = 1'b0;
            w_mv_pos[i] = r_pos[i];
        end
        for (int i = 0; i < NUM_CARS; i++) begin
            v_eff = r_dir[i] ^ i_turn[i];
            if (v_eff && (r_pos[i] == TOP_FLOOR)) begin
                v_eff = 1'b0;
            end else if (!v_eff && (r_pos[i] == BOTTOM_FLOOR)) begin
                v_eff = 1'b1;
            end
            w_mv_dir[i] = v_eff;
            w_mv_pos[i] = v_eff ? (r_pos[i] + ONE_FLOOR) : (r_pos[i] - ONE_FLOOR);
        end
    end

    // For each car, find the lowest-numbered other car on the same floor. A car leaving
    // FROZEN takes the opposite of that car's pre-edge direction, so the two cars split up.
    always_comb begin
        for (int i = 0; i < NUM_CARS; i++) begin
            w_peer_hit[i] = 1'b0;
            w_peer_dir[i] = 1'b0;
            // Scan downwards so the lowest matching index is the one that sticks.
            for (int j = NUM_CARS - 1; j >= 0; j--) begin
                if ((j != i) && (r_pos[j] == r_pos[i])) begin
                    w_peer_hit[i] = 1'b1;
                    w_peer_dir[i] = r_dir[j];
                end
            end
        end
    end

    // Per-car state machine. Priority is reset, then emergency (which needs no step),
    // then the step-qualified MOVE / DWELL / FROZEN behaviour.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the per-car arrays are control state, not bulk storage, so every
            // element is reset. Otherwise a car could come out of reset mid-dwell.
            for (int i = 0; i < NUM_CARS; i++) begin
                r_pos[i]   <= '0;
                r_state[i] <= ST_MOVE;
                r_cnt[i]   <= '0;
            end
            r_dir  <= '1;
            r_door <= '0;
        end else begin
            for (int i = 0; i < NUM_CARS; i++) begin
                // NOTE: non-blocking assignments throughout, so every car reads the same
                // pre-edge positions and directions, whatever the loop order.
                if (i_emergency[i]) begin
                    r_state[i] <= ST_FROZEN;
                    r_door[i]  <= 1'b0;
                    r_cnt[i]   <= '0;
                end else if (i_step) begin
                    case (r_state[i])
                        ST_FROZEN: begin
                            // Leaving FROZEN uses up this step. The car does not move and turn is ignored.
                            r_state[i] <= ST_MOVE;
                            if (w_peer_hit[i]) begin
                                r_dir[i] <= ~w_peer_dir[i];
                            end
                        end
                        ST_MOVE: begin
                            if (i_hold[i]) begin
                                r_state[i] <= ST_DWELL;
                                r_cnt[i]   <= DWELL_RELOAD;
                                r_door[i]  <= 1'b1;
                            end else begin
                                r_pos[i] <= w_mv_pos[i];
                                r_dir[i] <= w_mv_dir[i];
                            end
                        end
                        ST_DWELL: begin
                            if (i_hold[i]) begin
                                r_cnt[i] <= DWELL_RELOAD;
                            end else if (r_cnt[i] == '0) begin
                                r_state[i] <= ST_MOVE;
                                r_door[i]  <= 1'b0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                            end
                        end
                        default: begin
                            // The unused encoding recovers to a closed, moving car.
                            r_state[i] <= ST_MOVE;
                            r_door[i]  <= 1'b0;
                            r_cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Pack the per-car registers onto the flat output buses.
    for (genvar g = 0; g < NUM_CARS; g++) begin : g_out
        assign o_pos[g*FLOOR_W +: FLOOR_W] = r_pos[g];
        assign o_state[2*g +: 2]           = r_state[g];
    end

    assign o_dir       = r_dir;
    assign o_door_open = r_door;

endmodule

// File: doc/elevator_bank.md
# elevator_bank

Parametrised multi-car elevator position controller. It generalises the two-car floor stepper to `NUM_CARS` cars and `NUM_FLOORS` floors. It adds three things:
- a per-car state machine with a door dwell timer;
- automatic reversal at the top and bottom floors;
- an explicit step enable.

It sits between the request/scheduling logic, which drives `turn` and `hold`, and the display/status logic, which consumes `pos`, `dir`, `state` and `door_open`.

## Interface
- `NUM_CARS`, default 2: number of independent cars.
- `NUM_FLOORS`, default 6: floors are numbered 0 to `NUM_FLOORS-1`.
- `FLOOR_W`, default 3: floor index width. It must satisfy 2^`FLOOR_W` >= `NUM_FLOORS`.
- `DWELL`, default 3: number of steps the door stays open. Must be >= 1.
- `clock`  in  1  sole clock. All state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `step`  in  1  advance enable. One step is one floor-travel interval.
- `emergency`  in  `NUM_CARS`  bit i freezes car i.
- `turn`  in  `NUM_CARS`  bit i requests a direction reversal of car i on its next move step.
- `hold`  in  `NUM_CARS`  bit i requests a stop at car i's current floor.
- `pos`  out  `NUM_CARS*FLOOR_W`  car i floor index at bits [i*`FLOOR_W` +: `FLOOR_W`]. Registered.
- `dir`  out  `NUM_CARS`  1 = up, 0 = down. Registered.
- `state`  out  `2*NUM_CARS`  car i state at bits [2i +: 2]. Encoding: MOVE=00, DWELL=01, FROZEN=10. Registered.
- `door_open`  out  `NUM_CARS`  1 while car i is in DWELL. Registered.

## Operation
Each car has its own state machine. The only cross-car dependency is the exit from FROZEN.
- **Reset:** all `pos`=0, `dir`=1, `state`=MOVE, `door_open`=0, dwell counters=0.
- **Emergency (highest priority):** evaluated every cycle, regardless of `step`. While `emergency[i]`=1:
  - `state`=FROZEN, `door_open`=0, dwell counter cleared;
  - `pos` and `dir` held.
- **FROZEN**, with `emergency[i]`=0 and `step`=1: the car goes to MOVE with no movement on that step.
  - If any other car j shares `pos[i]`, take the lowest such j: `dir[i]` <= ~`dir[j]`, using the pre-edge value.
  - Otherwise `dir[i]` is unchanged.
  - `turn[i]` is ignored on this step.
- **MOVE**, with `step`=1:
  - If `hold[i]`: go to DWELL, counter <= `DWELL`-1, `door_open`=1, `pos` held. `turn[i]` is ignored.
  - Otherwise compute the effective direction e = `dir[i]` ^ `turn[i]`.
    - If e=1 and `pos`=`NUM_FLOORS`-1, force e=0.
    - If e=0 and `pos`=0, force e=1.
    - Then `pos` <= `pos` +1 if e=1, or `pos` -1 if e=0, and `dir` <= e.
    - `pos` never leaves 0 to `NUM_FLOORS`-1 and never wraps.
- **DWELL**, with `step`=1:
  - If `hold[i]`: counter reloads to `DWELL`-1 and the car stays in DWELL.
  - Else if counter=0: go to MOVE, `door_open`=0, no movement on this step.
  - Else counter decrements.
  - `turn[i]` during DWELL is ignored, not remembered.
- With `step`=0, nothing changes except emergency entry.
- All arithmetic is `FLOOR_W` bits wide. The counter width is clog2(`DWELL`), minimum 1.

## Timing
- All outputs are registered. Effects are visible the cycle after the qualifying edge.
- Move latency: one `step` per floor.
- A stop is open for exactly `DWELL` steps without re-hold. The first move occurs on the step after the car leaves DWELL, i.e. `DWELL`+1 steps after the hold step.
- Emergency entry: 1 clock, `step` not required. Exit: the first `step` with `emergency` low, then movement begins on the following step.
- Simultaneous events, in priority order: `reset` > `emergency` > `hold` > `turn`/bound reversal.
- Reset asserted mid-dwell or mid-freeze returns everything to reset values on the next edge.

## Test plan
- Reset, then 5 steps with no inputs (`NUM_FLOORS`=6) -> car 0 `pos` 0,1,2,3,4,5, `dir`=1. The 6th step -> `pos`=4, `dir`=0 (top reversal).
- Car 0 at 2, going up, `turn`[0]=1 on one step -> `pos`=1, `dir`=0. The next step without `turn` -> `pos`=0. The following step -> `pos`=1, `dir`=1 (bottom reversal).
- Car 1 at 3 with `hold`[1]=1 for one step, `DWELL`=3 -> `door_open`[1]=1 for 3 steps, `state`=DWELL then MOVE on the 4th step, `pos`=4 on the 5th step. A re-hold on the 2nd dwell step extends the door time to 5 steps.
- `emergency`[0] raised with `step`=0 -> `state`[0]=FROZEN next clock. Steps while frozen leave `pos` unchanged. Car 1 keeps moving.
- Both cars at 3 with `dir`[1]=1. Release `emergency`[0] and step -> car 0 `state`=MOVE, `dir`[0]=0, `pos` still 3. The next step -> `pos`[0]=2.
- `reset` pulsed while car 0 is in DWELL with counter 1 and car 1 is FROZEN -> all `pos`=0, `dir`=1, `state`=MOVE, `door_open`=0.
